move_scheduler: RTL and testbench

- Sequences player movement for the level-play datapath.
- Turns raw up/down/left/right key levels into one-hot, frame-rate-paced single-cycle move strobes, which feed the player bounding-box/collision block's direction inputs.
- Arbitrates simultaneous keys round-robin.
- Provides tap-to-step plus hold-to-autorepeat timing, so the player moves a fixed number of steps per frame instead of once per clock.

---
 rtl/move_scheduler.sv | 189 ++++++++++++++++++
 tb/tb_move_scheduler.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/move_scheduler.sv
// ---------------------------------------------------------------------------
// move_scheduler
//
// Turns raw direction key levels into one-hot, frame-paced, single-cycle move
// strobes for the player collision block. Held keys are arbitrated
// round-robin. A tap gives one step at the next frame tick. Holding the key
// gives autorepeat: the first repeat comes after REPEAT_DELAY ticks, and the
// following repeats every REPEAT_RATE ticks.
//
// Ports
//   clk        in   system clock
//   reset      in   asynchronous, active-high reset
//   enable     in   game running; no moves are issued while low
//   up/down/left/right   in   raw key levels, asynchronous to clk
//   move_up/move_down/move_left/move_right   out  one-cycle move strobes
//   tick       out  one-cycle frame tick, period TICK_DIV
//   busy       out  high whenever the scheduler is not idle
// ---------------------------------------------------------------------------
module move_scheduler #(
    parameter int TICK_DIV     = 833333,  // clk cycles per movement tick, >= 2
    parameter int REPEAT_DELAY = 15,      // ticks from first move to first repeat, 1..255
    parameter int REPEAT_RATE  = 2        // ticks between repeat moves, 1..255
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic up,
    input  logic down,
    input  logic left,
    input  logic right,
    output logic move_up,
    output logic move_down,
    output logic move_left,
    output logic move_right,
    output logic tick,
    output logic busy
);

    localparam int              CNT_W    = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [7:0]      DELAY_LD = 8'(REPEAT_DELAY);
    localparam logic [7:0]      RATE_LD  = 8'(REPEAT_RATE);

    // Each direction's index is its position in the ring order
    // up -> right -> down -> left -> up. Starting the pointer at left
    // therefore gives up first priority.
    localparam logic [1:0] DIR_LEFT = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARMED  = 2'd1,
        S_HOLD   = 2'd2,
        S_REPEAT = 2'd3
    } state_t;

    // Key vectors use the ring index as the bit position.
    logic [3:0]       w_key_raw;
    logic [3:0]       r_key_meta;
    logic [3:0]       r_key_sync;

    logic [CNT_W-1:0] r_tick_cnt;
    logic             r_tick;

    state_t           r_state;
    state_t           w_state_next;
    logic [1:0]       r_cur_dir;
    logic [1:0]       w_cur_dir_next;
    logic [1:0]       r_ptr;
    logic [1:0]       w_ptr_next;
    logic [7:0]       r_rep_cnt;
    logic [7:0]       w_rep_next;
    logic [3:0]       r_move;
    logic [3:0]       w_move_next;

    logic [1:0]       w_arb_dir;
    logic             w_arb_found;
    logic [1:0]       w_idx;

    assign w_key_raw = {left, down, right, up};

    // Two-flop synchronizer for the asynchronous key levels.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_key_meta <= 4'b0;
            r_key_sync <= 4'b0;
        end else begin
            r_key_meta <= w_key_raw;
            r_key_sync <= r_key_meta;
        end
    end

    // Free-running frame tick generator. It keeps running while enable is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tick_cnt <= '0;
            r_tick     <= 1'b0;
        end else begin
            r_tick <= (r_tick_cnt == CNT_LAST);
            if (r_tick_cnt == CNT_LAST) begin
                r_tick_cnt <= '0;
            end else begin
                r_tick_cnt <= r_tick_cnt + 1'b1;
            end
        end
    end

    // Round-robin search. It starts at the entry after the last direction
    // that produced a strobe, and the first held synchronized key wins.
    always_comb begin
        w_arb_dir   = r_ptr;
        w_arb_found = 1'b0;
        w_idx       = r_ptr;
        for (int i = 1; i <= 4; i++) begin
            w_idx = r_ptr + 2'(i);
            if (!w_arb_found && r_key_sync[w_idx]) begin
                w_arb_found = 1'b1;
                w_arb_dir   = w_idx;
            end
        end
    end

    // Next-state logic. In every non-idle state, a release or a disable is
    // checked before the tick. A tick that arrives together with a release
    // therefore never produces a strobe.
    always_comb begin
        w_state_next   = r_state;
        w_cur_dir_next = r_cur_dir;
        w_ptr_next     = r_ptr;
        w_rep_next     = r_rep_cnt;
        w_move_next    = 4'b0;

        if (r_state == S_IDLE) begin
            if (enable && w_arb_found) begin
                w_cur_dir_next = w_arb_dir;
                w_state_next   = S_ARMED;
            end
        end else if (!enable) begin
            w_state_next = S_IDLE;
        end else if (!r_key_sync[r_cur_dir]) begin
            // The current key is released, so hand over to another held key.
            if (w_arb_found) begin
                w_cur_dir_next = w_arb_dir;
                w_state_next   = S_ARMED;
            end else begin
                w_state_next = S_IDLE;
            end
        end else if (r_tick) begin
            if (r_state == S_ARMED) begin
                w_move_next  = 4'b0001 << r_cur_dir;
                w_ptr_next   = r_cur_dir;
                w_rep_next   = DELAY_LD;
                w_state_next = S_HOLD;
            end else if (r_rep_cnt == 8'd1) begin
                // HOLD and REPEAT share the countdown. Both reload with the
                // repeat rate and settle in REPEAT.
                w_move_next  = 4'b0001 << r_cur_dir;
                w_ptr_next   = r_cur_dir;
                w_rep_next   = RATE_LD;
                w_state_next = S_REPEAT;
            end else begin
                w_rep_next = r_rep_cnt - 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cur_dir <= 2'd0;
            r_ptr     <= DIR_LEFT;
            r_rep_cnt <= 8'd0;
            r_move    <= 4'b0;
        end else begin
            r_state   <= w_state_next;
            r_cur_dir <= w_cur_dir_next;
            r_ptr     <= w_ptr_next;
            r_rep_cnt <= w_rep_next;
            r_move    <= w_move_next;
        end
    end

    assign move_up    = r_move[0];
    assign move_right = r_move[1];
    assign move_down  = r_move[2];
    assign move_left  = r_move[3];
    assign tick       = r_tick;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_move_scheduler.sv
// ---------------------------------------------------------------------------
// tb_move_scheduler
//
// Directed bench for move_scheduler with TICK_DIV=4, REPEAT_DELAY=3 and
// REPEAT_RATE=2. Cycle n counts the posedges since the most recent reset
// release, and every sample is taken on the negedge. Ticks are seen at
// n = 4, 8, 12, ... A strobe triggered by a tick appears one cycle later.
// ---------------------------------------------------------------------------
module tb_move_scheduler;

    localparam int TD = 4;
    localparam int RD = 3;
    localparam int RR = 2;

    logic clk    = 1'b0;
    logic reset  = 1'b1;
    logic enable = 1'b1;
    logic up     = 1'b0;
    logic down   = 1'b0;
    logic left   = 1'b0;
    logic right  = 1'b0;
    logic move_up, move_down, move_left, move_right, tick, busy;
    logic [3:0] mv;

    int n_total = 0;
    int n_bad   = 0;

    // Per-window tables. ev = input changes {enable, left, down, right, up}
    // applied after sampling at cycle n; st = expected strobe vectors;
    // bz = expected busy values.
    int         ev_n[$];
    logic [4:0] ev_v[$];
    int         st_n[$];
    logic [3:0] st_v[$];
    int         bz_n[$];
    logic       bz_v[$];

    move_scheduler #(
        .TICK_DIV    (TD),
        .REPEAT_DELAY(RD),
        .REPEAT_RATE (RR)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .up        (up),
        .down      (down),
        .left      (left),
        .right     (right),
        .move_up   (move_up),
        .move_down (move_down),
        .move_left (move_left),
        .move_right(move_right),
        .tick      (tick),
        .busy      (busy)
    );

    assign mv = {move_left, move_down, move_right, move_up};

    always #5 clk = ~clk;

    initial begin
        assert (RD >= 1 && RD <= 255 && RR >= 1 && RR <= 255)
            else $fatal(1, "illegal repeat parameter");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic [4:0] v);
        enable = v[4];
        {left, down, right, up} = v[3:0];
    endtask

    task automatic release_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic start_test(input logic [4:0] v);
        reset = 1'b1;
        set_in(v);
        release_reset();
    endtask

    task automatic add_ev(input int n, input logic [4:0] v);
        ev_n.push_back(n);
        ev_v.push_back(v);
    endtask

    task automatic add_st(input int n, input logic [3:0] v);
        st_n.push_back(n);
        st_v.push_back(v);
    endtask

    task automatic add_bz(input int n, input logic v);
        bz_n.push_back(n);
        bz_v.push_back(v);
    endtask

    task automatic run_window(input string tag, input int ncyc);
        logic [3:0] exp_mv;
        for (int n = 1; n <= ncyc; n++) begin
            @(negedge clk);
            exp_mv = 4'b0;
            foreach (st_n[i]) if (st_n[i] == n) exp_mv = st_v[i];
            chk($sformatf("%s_move_n%0d", tag, n), mv, exp_mv);
            foreach (bz_n[i]) if (bz_n[i] == n) chk($sformatf("%s_busy_n%0d", tag, n), busy, bz_v[i]);
            foreach (ev_n[i]) if (ev_n[i] == n) set_in(ev_v[i]);
        end
        ev_n.delete(); ev_v.delete();
        st_n.delete(); st_v.delete();
        bz_n.delete(); bz_v.delete();
        $display("window %s: %0d cycles, total=%0d", tag, ncyc, n_total);
    endtask

    task automatic check_ticks(input string tag, input int ncyc);
        for (int n = 1; n <= ncyc; n++) begin
            @(negedge clk);
            chk($sformatf("%s_tick_n%0d", tag, n), tick, (n % TD) == 0);
        end
        $display("ticks %s: %0d cycles, total=%0d", tag, ncyc, n_total);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // 1. Reset state and tick cadence. Then apply an async reset while
        //    tick is high, and another one mid-count.
        repeat (3) @(negedge clk);
        chk("rst_move", mv, 4'b0);
        chk("rst_tick", tick, 1'b0);
        chk("rst_busy", busy, 1'b0);
        reset = 1'b0;
        check_ticks("t1a", 12);
        reset = 1'b1;
        #1;
        chk("t1_async_tick", tick, 1'b0);
        chk("t1_async_busy", busy, 1'b0);
        release_reset();
        repeat (6) @(negedge clk);
        reset = 1'b1;
        #1;
        release_reset();
        check_ticks("t1b", 8);

        // 2. A short up press gives exactly one move. The key is held through
        //    reset release, so it counts as a new press.
        start_test(5'b1_0001);
        add_st(5, 4'b0001);
        add_ev(6, 5'b1_0000);
        add_bz(2, 1'b0); add_bz(3, 1'b1); add_bz(8, 1'b1); add_bz(9, 1'b0);
        run_window("t2", 20);

        // 3. Hold right for autorepeat: T0, T0+3, T0+5, T0+7, T0+9.
        start_test(5'b1_0010);
        add_st(5, 4'b0010); add_st(17, 4'b0010); add_st(25, 4'b0010);
        add_st(33, 4'b0010); add_st(41, 4'b0010);
        add_ev(42, 5'b1_0000);
        run_window("t3", 50);

        // 4. Round-robin. After reset, up beats down. Releasing up hands over
        //    to down, and the tick that coincides with the release is lost.
        //    With the pointer then at down, the search starts at left, so up
        //    wins again. Releasing up then hands over to down.
        start_test(5'b1_0101);
        add_st(5, 4'b0001); add_st(13, 4'b0100);
        add_st(25, 4'b0001); add_st(33, 4'b0100);
        add_ev(6, 5'b1_0100); add_ev(14, 5'b1_0000); add_ev(18, 5'b1_0101);
        add_ev(26, 5'b1_0100); add_ev(34, 5'b1_0000);
        add_bz(17, 1'b0); add_bz(20, 1'b0); add_bz(21, 1'b1);
        run_window("t4", 40);

        // 5. enable low with left held gives no moves. Raising enable arms
        //    the next cycle and then autorepeats.
        start_test(5'b0_1000);
        add_st(37, 4'b1000); add_st(49, 4'b1000);
        add_st(57, 4'b1000); add_st(65, 4'b1000);
        add_ev(32, 5'b1_1000); add_ev(66, 5'b1_0000);
        add_bz(16, 1'b0); add_bz(32, 1'b0); add_bz(33, 1'b1);
        run_window("t5", 66);

        // 6. Reset in REPEAT while down is held clears the strobe at once.
        //    After release, the full delay spacing applies again.
        start_test(5'b1_0100);
        add_st(5, 4'b0100); add_st(17, 4'b0100); add_st(25, 4'b0100);
        run_window("t6a", 25);
        reset = 1'b1;
        #1;
        chk("t6_rst_move", mv, 4'b0);
        chk("t6_rst_busy", busy, 1'b0);
        release_reset();
        add_st(5, 4'b0100); add_st(17, 4'b0100);
        add_bz(2, 1'b0); add_bz(3, 1'b1);
        run_window("t6b", 20);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
